instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control decoder.
- Holds the PC and runs a request/acknowledge handshake to instruction memory.
- Presents the fetched word, and its opcode field instr[31:26], to the decoder/datapath until the datapath retires it.
- Computes the next PC from the retired instruction's Branch/Zero/Jump outcome: sequential, BEQ target or J target.

---
 rtl/instr_fetch_unit_if.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the instruction-memory handshake and the decoder/datapath-facing
//   signals of the fetch stage.
//
//   master : the fetch unit (drives imem_req/imem_addr and the instr outputs)
//   slave  : memory + decoder/datapath side
//
//   Signals:
//     imem_req, imem_addr        fetch request / byte address (addr = pc)
//     imem_ack, imem_rdata       acknowledge, data valid in the same cycle
//     instr, opcode, instr_valid captured word, its [31:26], occupancy flag
//     instr_ready                datapath retires instr this cycle
//     branch, zero, jump         retirement outcome for the current instr
//     imm_sext                   sign-extended instr[15:0]
//     pc                         address of instr / current fetch
//     fetch_err                  sticky timeout flag (IMEM_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] imm_sext;
  logic [31:0] pc;
`ifdef IMEM_TIMEOUT_EN
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, jump, imm_sext
  );
  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_err,
    output imem_ack, imem_rdata, instr_ready, branch, zero, jump, imm_sext
  );
`else
  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, jump, imm_sext
  );
  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc,
    output imem_ack, imem_rdata, instr_ready, branch, zero, jump, imm_sext
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the control decoder. Holds the PC, runs a
//   req/ack handshake to instruction memory, presents the fetched word until
//   the datapath retires it, then computes the next PC (sequential, BEQ
//   target or J target; jump has priority over branch).
//
//   Optional feature macro: IMEM_TIMEOUT_EN
//     Adds an 8-bit wait counter, an ERR state and the sticky fetch_err output.
//     Without it FETCH waits for imem_ack indefinitely.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    instr_fetch_unit_if.master (memory handshake + decoder signals)
//
//   Parameters:
//     RESET_PC        PC loaded on reset (word aligned)
//     TIMEOUT_CYCLES  ack wait limit, 2..255 (IMEM_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef IMEM_TIMEOUT_EN
  localparam logic [1:0] S_ERR   = 2'd3;
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
`endif

  // Low bits are dropped so pc[1:0] is zero even for a misconfigured value.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  // Elaboration-time sanity check of the configuration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYCLES out of range 2..255");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
`ifdef IMEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        fetch_err_q, fetch_err_d;
`endif

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // Next-PC arithmetic; all additions wrap modulo 2^32.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    branch_target = pc_plus4 + (bus.imm_sext << 2);
    if (bus.jump) begin
      next_pc = jump_target;
    end else if (bus.branch && bus.zero) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
    next_pc = next_pc & ~32'd3;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
`ifdef IMEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    fetch_err_d   = fetch_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
`ifdef IMEM_TIMEOUT_EN
        cnt_d      = 8'd0;
`endif
      end
      S_FETCH: begin
        // An ack on the limit cycle takes precedence over the timeout.
        if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = S_HOLD;
        end
`ifdef IMEM_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d     = S_ERR;
          fetch_err_d = 1'b1;
          imem_req_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = S_FETCH;
`ifdef IMEM_TIMEOUT_EN
          cnt_d         = 8'd0;
`endif
        end
      end
`ifdef IMEM_TIMEOUT_EN
      S_ERR: begin
        // Terminal until reset.
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b1;
      end
`endif
      default: begin
        state_d       = S_IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
      cnt_q         <= 8'd0;
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
`ifdef IMEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      fetch_err_q   <= fetch_err_d;
`endif
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.instr_valid = instr_valid_q;
`ifdef IMEM_TIMEOUT_EN
  assign bus.fetch_err   = fetch_err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed scoreboard bench. The stimulus pushes expected fetch addresses
//   and expected captures into queues; a monitor pops and compares whenever
//   the DUT raises imem_req or instr_valid.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } cap_t;

  logic [31:0] exp_addr_q[$];
  cap_t        exp_cap_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] cur_pc = 32'h0;
  logic req_prev = 1'b0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.imem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL fetch_addr: unexpected request at 0x%08h, expected none", ifc.imem_addr);
        end else begin
          logic [31:0] ea;
          ea = exp_addr_q.pop_front();
          check("fetch_addr", ifc.imem_addr, ea);
          $display("fetch request addr=0x%08h", ifc.imem_addr);
        end
      end
      if (ifc.instr_valid && !valid_prev) begin
        if (exp_cap_q.size() == 0) begin
          n_checks++;
          $display("FAIL capture: unexpected instr 0x%08h, expected none", ifc.instr);
        end else begin
          cap_t ec;
          ec = exp_cap_q.pop_front();
          check("cap_instr", ifc.instr, ec.instr);
          check("cap_opcode", {26'd0, ifc.opcode}, {26'd0, ec.instr[31:26]});
          check("cap_pc", ifc.pc, ec.pc);
          $display("capture pc=0x%08h instr=0x%08h opcode=%06b", ifc.pc, ifc.instr, ifc.opcode);
        end
      end
    end
    req_prev   = ifc.imem_req;
    valid_prev = ifc.instr_valid;
  end

  // One fetch/retire transaction; called at a negedge, returns at a negedge.
  task automatic do_fetch(input logic [31:0] w, input int dly, input int hold,
                          input logic br, input logic zr, input logic jp,
                          input logic [31:0] imm, input logic [31:0] nxt);
    int t;
    exp_cap_q.push_back('{cur_pc, w});
    t = 0;
    while (!ifc.imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'd0, ifc.imem_req}, 32'd1);
    check("addr_eq_pc", ifc.imem_addr, cur_pc);
    // instr_ready and jump are asserted during FETCH to show they are ignored.
    repeat (dly) begin
      ifc.instr_ready = 1'b1;
      ifc.jump        = 1'b1;
      @(negedge clk);
      check("wait_no_valid", {31'd0, ifc.instr_valid}, 32'd0);
      check("wait_addr", ifc.imem_addr, cur_pc);
    end
    ifc.instr_ready = 1'b0;
    ifc.jump        = 1'b0;
    ifc.imem_ack    = 1'b1;
    ifc.imem_rdata  = w;
    @(negedge clk);
    ifc.imem_ack = 1'b0;
    check("capture_valid", {31'd0, ifc.instr_valid}, 32'd1);
    check("capture_req_low", {31'd0, ifc.imem_req}, 32'd0);
    // Stray acks with different data during HOLD must not disturb instr.
    repeat (hold) begin
      ifc.imem_ack   = 1'b1;
      ifc.imem_rdata = ~w;
      @(negedge clk);
      check("hold_instr", ifc.instr, w);
      check("hold_pc", ifc.pc, cur_pc);
      check("hold_valid_req", {30'd0, ifc.instr_valid, ifc.imem_req}, 32'd2);
    end
    ifc.imem_ack    = 1'b0;
    ifc.imem_rdata  = w;
    ifc.branch      = br;
    ifc.zero        = zr;
    ifc.jump        = jp;
    ifc.imm_sext    = imm;
    ifc.instr_ready = 1'b1;
    exp_addr_q.push_back(nxt);
    @(negedge clk);
    ifc.instr_ready = 1'b0;
    ifc.branch      = 1'b0;
    ifc.zero        = 1'b0;
    ifc.jump        = 1'b0;
    ifc.imm_sext    = 32'd0;
    check("retire_pc", ifc.pc, nxt);
    check("retire_valid_low", {31'd0, ifc.instr_valid}, 32'd0);
    $display("retire instr=0x%08h br=%0b zr=%0b jp=%0b -> pc=0x%08h", w, br, zr, jp, ifc.pc);
    cur_pc = nxt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.imem_ack    = 1'b0;
    ifc.imem_rdata  = 32'd0;
    ifc.instr_ready = 1'b0;
    ifc.branch      = 1'b0;
    ifc.zero        = 1'b0;
    ifc.jump        = 1'b0;
    ifc.imm_sext    = 32'd0;

    #3 rst_n = 1'b0;
    #1;
    check("rst_pc", ifc.pc, 32'h0);
    check("rst_instr", ifc.instr, 32'h0);
    check("rst_opcode", {26'd0, ifc.opcode}, 32'h0);
    check("rst_valid_req", {30'd0, ifc.instr_valid, ifc.imem_req}, 32'd0);
`ifdef IMEM_TIMEOUT_EN
    check("rst_fetch_err", {31'd0, ifc.fetch_err}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;

    //        word          dly hold br    zr    jp    imm_sext      next pc
    do_fetch(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);
    do_fetch(32'h0000_0020, 1, 5, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008);
    do_fetch(32'h0800_0004, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0010);
    do_fetch(32'h1000_FFFE, 0, 1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_000C);
    do_fetch(32'h0800_0004, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0010);
    do_fetch(32'h1000_FFFE, 3, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0014);
    do_fetch(32'h1000_0002, 0, 0, 1'b1, 1'b1, 1'b0, 32'h1000_0002, 32'h4000_0020);
    do_fetch(32'h0800_0100, 0, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h4000_0400);
    do_fetch(32'h1000_FEFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'h2FFF_FEFE, 32'hFFFF_FFFC);
    do_fetch(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    do_fetch(32'h0000_0020, 2, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);

    // Reset in the middle of the fetch at pc=4, away from any clock edge.
    @(negedge clk);
    check("midfetch_req", {31'd0, ifc.imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, ifc.imem_req}, 32'd0);
    check("async_rst_pc", ifc.pc, 32'h0);
    check("async_rst_valid", {31'd0, ifc.instr_valid}, 32'd0);
    $display("async reset mid-fetch: req=%0b pc=0x%08h", ifc.imem_req, ifc.pc);
    @(negedge clk);
    exp_addr_q.push_back(32'h0);
    cur_pc = 32'h0;
    rst_n = 1'b1;
    do_fetch(32'h8C01_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);

`ifdef IMEM_TIMEOUT_EN
    // No ack: error after 4 FETCH cycles, and it stays latched.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_addr_q.push_back(32'h0);
    cur_pc = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    check("to_req_up", {31'd0, ifc.imem_req}, 32'd1);
    repeat (3) @(negedge clk);
    check("to_not_yet", {30'd0, ifc.fetch_err, ifc.imem_req}, 32'd1);
    @(negedge clk);
    check("to_err_set", {30'd0, ifc.fetch_err, ifc.imem_req}, 32'd2);
    $display("timeout: fetch_err=%0b req=%0b", ifc.fetch_err, ifc.imem_req);
    ifc.imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    ifc.imem_ack = 1'b0;
    check("to_err_sticky", {29'd0, ifc.fetch_err, ifc.imem_req, ifc.instr_valid}, 32'd4);
    // Ack on the 4th FETCH cycle wins over the timeout.
    rst_n = 1'b0;
    @(negedge clk);
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    do_fetch(32'h2008_0005, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004);
    check("to_ack_wins_err", {31'd0, ifc.fetch_err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);
    check("cap_queue_drained", exp_cap_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
